frame_draw_sequencer: RTL and testbench
=======================================

// Module: frame_draw_sequencer
// PURPOSE
//  Sits downstream of the sprite drawers (road/background, player car, crash scene) and upstream of
//  the VGA adapter. On each frame request it optionally clears the 160x120 screen to a background
//  colour. It then runs up to three drawers in fixed order, one at a time. Only the active drawer's
//  x/y/colour/plot reach the VGA write port.
// PARAMETERS
//  SCREEN_W   160      pixels per row; clear x range 0..SCREEN_W-1
//  SCREEN_H   120      rows; clear y range 0..SCREEN_H-1
//  BG_COLOUR  3'b000   colour written during clear
//  TIMEOUT    16'd8191 max RUN cycles per drawer before it is abandoned
// PORTS
//  clock           in   1   system clock; all state on posedge
//  reset           in   1   synchronous, active-high; one clock; reset is synchronous and active-high
//  frame_req       in   1   1-cycle start pulse; ignored while busy=1
//  clear_en        in   1   sampled with frame_req: 1 = run CLEAR phase first
//  client_mask     in   3   sampled with frame_req: bit k = run drawer k
//  client_plot     in   3   plot from drawer k (bit k)
//  client_x        in   24  drawer k x at [8k+7:8k]
//  client_y        in   21  drawer k y at [7k+6:7k]
//  client_colour   in   9   drawer k colour at [3k+2:3k]
//  client_finish   in   3   drawer k finished; may stay high until that drawer is cleared
//  client_en       out  3   level start for drawer k; high for whole RUN(k)
//  client_clear    out  3   active-high drawer reset; top inverts it for drawers with active-low resetn
//  vga_x           out  8   pixel x to VGA adapter
//  vga_y           out  7   pixel y
//  vga_colour      out  3   pixel colour
//  vga_plot        out  1   write strobe
//  busy            out  1   high from the cycle after accepted frame_req until DONE
//  frame_done      out  1   1-cycle pulse at end of frame
//  timeout_err     out  3   sticky bit k = drawer k timed out; cleared on next accepted frame_req
// BEHAVIOUR
//  Reset: state IDLE; client_en=0, client_clear=3'b111 while reset high, vga_plot=0,
//   vga_x/y/colour=0, busy=0, frame_done=0, timeout_err=0. Reset mid-frame aborts immediately.
//  States:
//   IDLE: on frame_req, latch clear_en/client_mask, clear timeout_err, and go to CLEAR if
//    clear_en, else SEL with k=0.
//   CLEAR: raster counters cx (fastest) / cy; one pixel per cycle, vga_plot=1, vga_colour=BG_COLOUR.
//    After (SCREEN_W-1, SCREEN_H-1) go to SEL k=0. Exactly SCREEN_W*SCREEN_H plot cycles (19200).
//   SEL: if mask[k]=0, skip (k++). If mask[k]=1, go to ARM. If k==3, go to DONE. One cycle per visit.
//   ARM: client_clear[k]=1 for exactly 1 cycle; then RUN.
//   RUN: client_en[k]=1. vga_* = drawer k fields (combinational mux).
//    vga_plot = client_plot[k]. client_finish[k] is sampled only here.
//    On finish, client_en drops next cycle and the block goes to SEL with k+1.
//    A watchdog counts RUN cycles; at TIMEOUT, set timeout_err[k] and advance as if finished.
//   DONE: frame_done=1 for 1 cycle; return to IDLE.
//  Outside CLEAR/RUN, vga_plot=0. client_clear[k]=0 except during reset and ARM(k).
//  A stale finish from the previous frame is removed by ARM before RUN samples finish.
//  Finish on the first RUN cycle is legal: RUN lasts 1 cycle.
//  frame_req in the DONE cycle is ignored; accepted only in IDLE.
//  Finish of a non-selected drawer is ignored.
//  Widths: cx 8b and cy 7b wrap only via state exit. Watchdog is 16b and saturates.
//  No internal storage of pixel data; latency from client input to vga_* is 0 cycles.
// STRUCTURE
//  Shared package/header: state encodings (IDLE, CLEAR, SEL, ARM, RUN, DONE), SCREEN_W/H
//   defaults, and colour constants (BG black 3'b000, crash cyan 3'b011).
//  One sub-module: screen_clear_counter (cx/cy raster counter with start/last outputs).
//  FSM, index k, watchdog, and output mux stay in the top.
// TESTING
//  1. frame_req with clear_en=1 and mask=0 -> 19200 plot cycles, first (0,0), last (159,119),
//     colour 000 -> frame_done.
//  2. clear_en=0, mask=3'b101, finish after 40 cycles -> clear[0] pulse, then en[0] for 40 cycles,
//     then clear[2] pulse, then en[2]; drawer 1 is never enabled.
//  3. Drawer 2 plots (83,47) colour 011 while in RUN(2) -> vga_x=83, vga_y=47, vga_colour=011,
//     vga_plot=1 in the same cycle.
//  4. Drawer 1 finish held high from the prior frame -> ARM clears it; RUN waits for a fresh finish.
//  5. Drawer 0 never finishes with TIMEOUT=100 -> timeout_err=001 after 100 RUN cycles;
//     sequence continues to drawer 1.
//  6. Reset asserted mid-CLEAR and frame_req pulsed while busy -> next cycle IDLE with all outputs
//     at reset values; the busy-time request has no effect.

Source files
------------

// File: rtl/frame_draw_sequencer_pkg.sv
// Shared definitions for the frame draw sequencer: FSM state encoding,
// default screen geometry and the colour constants used by the drawers.
package frame_draw_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SEL,
    ST_ARM,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam int         DEF_SCREEN_W = 160;
  localparam int         DEF_SCREEN_H = 120;
  localparam int         NUM_CLIENTS  = 3;
  localparam logic [2:0] COLOUR_BG    = 3'b000;
  localparam logic [2:0] COLOUR_CRASH = 3'b011;

endpackage

// File: rtl/frame_draw_sequencer_screen_clear_counter.sv
// Raster counter for the screen clear: cx advances every step, cy advances
// when cx wraps. Leaving the clear state is what ends the sweep.
module screen_clear_counter #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       step,
  output logic [7:0] cx,
  output logic [6:0] cy,
  output logic       last
);

  localparam logic [7:0] X_LAST = 8'(SCREEN_W - 1);
  localparam logic [6:0] Y_LAST = 7'(SCREEN_H - 1);

  always_ff @(posedge clock) begin
    if (reset || start) begin
      cx <= '0;
      cy <= '0;
    end else if (step) begin
      if (cx == X_LAST) begin
        cx <= '0;
        cy <= cy + 7'd1;
      end else begin
        cx <= cx + 8'd1;
      end
    end
  end

  assign last = (cx == X_LAST) && (cy == Y_LAST);

endmodule

// File: rtl/frame_draw_sequencer.sv
// Per-frame sequencer: optional full-screen clear, then the masked drawers in
// order 0..2, each reset (ARM) then enabled (RUN) with its pixels muxed to VGA.
module frame_draw_sequencer
  import frame_draw_sequencer_pkg::*;
#(
  parameter int          SCREEN_W  = DEF_SCREEN_W,
  parameter int          SCREEN_H  = DEF_SCREEN_H,
  parameter logic [2:0]  BG_COLOUR = COLOUR_BG,
  parameter logic [15:0] TIMEOUT   = 16'd8191
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_req,
  input  logic        clear_en,
  input  logic [2:0]  client_mask,
  input  logic [2:0]  client_plot,
  input  logic [23:0] client_x,
  input  logic [20:0] client_y,
  input  logic [8:0]  client_colour,
  input  logic [2:0]  client_finish,
  output logic [2:0]  client_en,
  output logic [2:0]  client_clear,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot,
  output logic        busy,
  output logic        frame_done,
  output logic [2:0]  timeout_err
);

  state_t      state, state_next;
  logic [1:0]  idx, idx_next;
  logic [2:0]  mask, mask_next;
  logic [15:0] wd, wd_next;
  logic [2:0]  err_next;
  logic [2:0]  arm_clear;
  logic [7:0]  cx;
  logic [6:0]  cy;
  logic        clear_last;
  logic [3:0]  sel_onehot, mask_ext, plot_ext, finish_ext;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // idx reaches 3 only in SEL, so the padded bit makes index 3 read as zero
  assign sel_onehot = 4'b0001 << idx;
  assign mask_ext   = {1'b0, mask};
  assign plot_ext   = {1'b0, client_plot};
  assign finish_ext = {1'b0, client_finish};

  screen_clear_counter #(
    .SCREEN_W(SCREEN_W),
    .SCREEN_H(SCREEN_H)
  ) u_clear (
    .clock(clock),
    .reset(reset),
    .start(state == ST_IDLE),
    .step (state == ST_CLEAR),
    .cx   (cx),
    .cy   (cy),
    .last (clear_last)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      idx         <= '0;
      mask        <= '0;
      wd          <= '0;
      timeout_err <= '0;
    end else begin
      state       <= state_next;
      idx         <= idx_next;
      mask        <= mask_next;
      wd          <= wd_next;
      timeout_err <= err_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    mask_next  = mask;
    wd_next    = wd;
    err_next   = timeout_err;
    arm_clear  = 3'b000;
    client_en  = 3'b000;
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    vga_plot   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (frame_req) begin
          mask_next  = client_mask;
          err_next   = 3'b000;
          idx_next   = 2'd0;
          state_next = clear_en ? ST_CLEAR : ST_SEL;
        end
      end
      ST_CLEAR: begin
        vga_x      = cx;
        vga_y      = cy;
        vga_colour = BG_COLOUR;
        vga_plot   = 1'b1;
        if (clear_last) state_next = ST_SEL;
      end
      ST_SEL: begin
        if (idx == 2'd3)        state_next = ST_DONE;
        else if (mask_ext[idx]) state_next = ST_ARM;
        else                    idx_next   = idx + 2'd1;
      end
      ST_ARM: begin
        arm_clear  = sel_onehot[2:0];
        wd_next    = '0;
        state_next = ST_RUN;
      end
      ST_RUN: begin
        client_en = sel_onehot[2:0];
        case (idx)
          2'd0: begin
            vga_x = client_x[7:0];   vga_y = client_y[6:0];   vga_colour = client_colour[2:0];
          end
          2'd1: begin
            vga_x = client_x[15:8];  vga_y = client_y[13:7];  vga_colour = client_colour[5:3];
          end
          2'd2: begin
            vga_x = client_x[23:16]; vga_y = client_y[20:14]; vga_colour = client_colour[8:6];
          end
          default: ;
        endcase
        vga_plot = plot_ext[idx];
        // a finish arriving on the watchdog's last cycle still counts as a clean finish
        if (finish_ext[idx]) begin
          state_next = ST_SEL;
          idx_next   = idx + 2'd1;
        end else if (wd == TIMEOUT - 16'd1) begin
          err_next   = timeout_err | sel_onehot[2:0];
          state_next = ST_SEL;
          idx_next   = idx + 2'd1;
        end else begin
          wd_next = sat_inc(wd);
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign client_clear = reset ? 3'b111 : arm_clear;
  assign busy         = (state != ST_IDLE);
  assign frame_done   = (state == ST_DONE);

endmodule

// File: tb/tb_frame_draw_sequencer.sv
// Scoreboard bench: scripted drawer models feed the sequencer; a frame-level
// model queues expected clear/pixel/done events that a monitor pops and checks.
module tb_frame_draw_sequencer;

  localparam logic [15:0] TO  = 16'd100;
  localparam int          TOI = 100;
  localparam int K_PIX = 0, K_CLR = 1, K_DONE = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        frame_req = 1'b0, clear_en = 1'b0;
  logic [2:0]  client_mask = 3'b000, client_plot = 3'b000, client_finish = 3'b000;
  logic [23:0] client_x = '0;
  logic [20:0] client_y = '0;
  logic [8:0]  client_colour = '0;
  logic [2:0]  client_en, client_clear, vga_colour, timeout_err;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic        vga_plot, busy, frame_done;

  always #5 clock = ~clock;

  frame_draw_sequencer #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .frame_req(frame_req), .clear_en(clear_en),
    .client_mask(client_mask), .client_plot(client_plot), .client_x(client_x),
    .client_y(client_y), .client_colour(client_colour), .client_finish(client_finish),
    .client_en(client_en), .client_clear(client_clear), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot), .busy(busy), .frame_done(frame_done),
    .timeout_err(timeout_err)
  );

  typedef struct {int kind; int a; int b; int c; int d;} ev_t;
  ev_t exp_q[$];
  int  checks = 0, fails = 0;
  bit  mon_on = 1'b0;
  int  en_cnt[3];

  // drawer scripts: per drawer run length and per run-cycle pixel
  int  len_s[3];
  bit  pl_s[3][256];
  int  x_s[3][256], y_s[3][256], c_s[3][256];
  logic [2:0] cur_mask = 3'b000;
  int  run_cnt[3];
  bit  done_flag[3];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      if (fails < 40) $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic check_ev(input int kind, input int a, input int b, input int c, input int d);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      fails++;
      if (fails < 40) $display("FAIL unexpected_event: got kind %0d (%0d,%0d,%0d), expected none", kind, a, b, c);
      return;
    end
    e = exp_q.pop_front();
    chk("event_kind", kind, e.kind);
    chk("event_a", a, e.a);
    chk("event_b", b, e.b);
    chk("event_c", c, e.c);
    chk("event_d", d, e.d);
  endtask

  // Drawer models: inputs change on negedge, a drawer's run-cycle count restarts on its clear
  always @(negedge clock) begin
    logic [2:0]  fin, pl;
    logic [23:0] xs;
    logic [20:0] ys;
    logic [8:0]  cs;
    int  j;
    bit  active;
    for (int k = 0; k < 3; k++) begin
      j      = run_cnt[k];
      active = client_en[k] && (j < 256);
      pl[k]        = active ? pl_s[k][j] : 1'($urandom_range(0, 1));
      xs[8*k +: 8] = active ? 8'(x_s[k][j]) : 8'($urandom_range(0, 255));
      ys[7*k +: 7] = active ? 7'(y_s[k][j]) : 7'($urandom_range(0, 127));
      cs[3*k +: 3] = active ? 3'(c_s[k][j]) : 3'($urandom_range(0, 7));
      fin[k] = done_flag[k] || (client_en[k] && j == len_s[k] - 1) ||
               (!cur_mask[k] && $urandom_range(0, 1) == 1);
    end
    client_plot = pl; client_x = xs; client_y = ys; client_colour = cs; client_finish = fin;
    for (int k = 0; k < 3; k++) begin
      if (client_clear[k]) begin
        run_cnt[k]   = 0;
        done_flag[k] = 1'b0;
      end else if (client_en[k]) begin
        if (run_cnt[k] == len_s[k] - 1) done_flag[k] = 1'b1;
        run_cnt[k]++;
      end
    end
  end

  always @(negedge clock) begin
    #2;
    if (mon_on && !reset) begin
      for (int k = 0; k < 3; k++) if (client_en[k]) en_cnt[k]++;
      if (client_clear != 3'b000) check_ev(K_CLR, int'(client_clear), 0, 0, 0);
      if (vga_plot) check_ev(K_PIX, int'(vga_x), int'(vga_y), int'(vga_colour), 0);
      if (frame_done) begin
        check_ev(K_DONE, int'(timeout_err), en_cnt[0], en_cnt[1], en_cnt[2]);
        for (int k = 0; k < 3; k++) en_cnt[k] = 0;
      end
    end
  end

  task automatic gen_scripts(input int l0, input int l1, input int l2);
    len_s[0] = l0; len_s[1] = l1; len_s[2] = l2;
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 256; j++) begin
        pl_s[k][j] = 1'($urandom_range(0, 1));
        x_s[k][j]  = $urandom_range(0, 255);
        y_s[k][j]  = $urandom_range(0, 127);
        c_s[k][j]  = $urandom_range(0, 7);
      end
  endtask

  // Frame-level model: clear raster, then each masked drawer runs min(len, TIMEOUT) cycles
  task automatic build_expect(input bit clr, input logic [2:0] m);
    int n[3];
    int err;
    err = 0;
    if (clr)
      for (int y = 0; y < 120; y++)
        for (int x = 0; x < 160; x++) exp_q.push_back('{K_PIX, x, y, 0, 0});
    for (int k = 0; k < 3; k++) begin
      n[k] = 0;
      if (m[k]) begin
        exp_q.push_back('{K_CLR, 1 << k, 0, 0, 0});
        n[k] = (len_s[k] > TOI) ? TOI : len_s[k];
        if (len_s[k] > TOI) err |= (1 << k);
        for (int j = 0; j < n[k]; j++)
          if (pl_s[k][j]) exp_q.push_back('{K_PIX, x_s[k][j], y_s[k][j], c_s[k][j], 0});
      end
    end
    exp_q.push_back('{K_DONE, err, n[0], n[1], n[2]});
  endtask

  task automatic run_frame(input bit clr, input logic [2:0] m, input int budget,
                           input int busy_req_at, input bit req_on_done);
    int cnt;
    build_expect(clr, m);
    cur_mask = m;
    @(negedge clock);
    frame_req = 1'b1; clear_en = clr; client_mask = m;
    @(negedge clock);
    frame_req = 1'b0; clear_en = 1'($urandom_range(0, 1)); client_mask = 3'($urandom_range(0, 7));
    chk("busy_after_req", int'(busy), 1);
    cnt = 0;
    while (!frame_done && cnt < budget) begin
      @(negedge clock);
      cnt++;
      frame_req = (busy_req_at != 0 && cnt == busy_req_at);
      if (frame_req) begin client_mask = 3'b111; clear_en = 1'b0; end
    end
    frame_req = 1'b0;
    if (!frame_done) begin
      checks++;
      fails++;
      $display("FAIL frame_timeout: frame_done not seen within %0d cycles, expected it", budget);
      exp_q.delete();
      return;
    end
    if (req_on_done) begin frame_req = 1'b1; client_mask = 3'b111; clear_en = 1'b1; end
    @(negedge clock);
    frame_req = 1'b0;
    #3;
    chk("idle_after_done", int'(busy), 0);
    chk("queue_drained", exp_q.size(), 0);
    @(negedge clock);
    #3;
    chk("still_idle", int'(busy), 0);
    exp_q.delete();
  endtask

  initial begin
    int busy_cycles;
    for (int k = 0; k < 3; k++) begin en_cnt[k] = 0; run_cnt[k] = 0; done_flag[k] = 1'b0; end
    gen_scripts(1, 1, 1);
    repeat (2) @(negedge clock);
    #3;
    chk("rst_client_clear", int'(client_clear), 7);
    chk("rst_client_en", int'(client_en), 0);
    chk("rst_vga_plot", int'(vga_plot), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_timeout_err", int'(timeout_err), 0);
    chk("rst_vga_xy", int'(vga_x) + int'(vga_y) + int'(vga_colour), 0);
    reset = 1'b0;
    @(negedge clock);
    #3;
    chk("post_rst_clear", int'(client_clear), 0);
    mon_on = 1'b1;

    // full clear with no drawers; a request while busy must be ignored
    run_frame(1'b1, 3'b000, 25000, 60, 1'b0);

    // drawers 0 and 2 for 40 cycles, drawer 2 plots (83,47) crash cyan
    gen_scripts(40, 40, 40);
    pl_s[2][5] = 1'b1; x_s[2][5] = 83; y_s[2][5] = 47; c_s[2][5] = 3;
    run_frame(1'b0, 3'b101, 2000, 0, 1'b1);

    // drawer 1 keeps finish high from the previous frame; next run must wait for a fresh one
    gen_scripts(5, 5, 5);
    run_frame(1'b0, 3'b010, 2000, 0, 1'b0);
    gen_scripts(30, 30, 30);
    run_frame(1'b0, 3'b010, 2000, 0, 1'b0);

    // watchdog boundaries, one-cycle runs, empty frame
    gen_scripts(100, 7, 101);
    run_frame(1'b0, 3'b101, 2000, 0, 1'b0);
    gen_scripts(1, 1, 1);
    run_frame(1'b0, 3'b111, 2000, 0, 1'b0);
    run_frame(1'b0, 3'b000, 2000, 0, 1'b0);

    for (int f = 0; f < 8; f++) begin
      int l[3];
      for (int k = 0; k < 3; k++)
        l[k] = ($urandom_range(0, 5) == 0) ? $urandom_range(101, 130) : $urandom_range(1, 60);
      gen_scripts(l[0], l[1], l[2]);
      run_frame(1'b0, 3'($urandom_range(0, 7)), 2000, 0, 1'($urandom_range(0, 1)));
    end

    // drawer 0 never finishes within the watchdog; sequence moves on to drawer 1
    gen_scripts(150, 20, 9);
    run_frame(1'b0, 3'b011, 2000, 0, 1'b0);

    // reset during clear, after a request made while busy
    mon_on = 1'b0;
    @(negedge clock);
    frame_req = 1'b1; clear_en = 1'b1; client_mask = 3'b000;
    @(negedge clock);
    frame_req = 1'b0;
    repeat (300) @(negedge clock);
    #3;
    chk("abort_in_clear", int'(vga_plot), 1);
    @(negedge clock);
    frame_req = 1'b1; clear_en = 1'b0; client_mask = 3'b111;
    @(negedge clock);
    frame_req = 1'b0;
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    #3;
    chk("abort_busy", int'(busy), 0);
    chk("abort_vga_plot", int'(vga_plot), 0);
    chk("abort_client_en", int'(client_en), 0);
    chk("abort_client_clear", int'(client_clear), 7);
    chk("abort_timeout_err", int'(timeout_err), 0);
    chk("abort_vga_xy", int'(vga_x) + int'(vga_y), 0);
    reset = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      #3;
      if (busy || vga_plot || client_clear != 3'b000) busy_cycles++;
    end
    chk("abort_stays_idle", busy_cycles, 0);
    exp_q.delete();
    for (int k = 0; k < 3; k++) en_cnt[k] = 0;
    mon_on = 1'b1;

    gen_scripts(12, 25, 3);
    run_frame(1'b0, 3'b111, 2000, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL global_timeout: simulation still running, expected finish");
    $fatal(1, "global time limit reached");
  end

endmodule
